uram_rd_adapter: RTL and testbench

URAM_RD_ADAPTER -- requirements
Module: uram_rd_adapter

---
 rtl/uram_rd_pkg.sv | 18 +
 rtl/uram_rd_fifo.sv | 71 +++++++
 rtl/uram_rd_adapter.sv | 115 +++++++++++
 tb/tb_uram_rd_adapter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_rd_pkg.sv
// +----------------------------------------------------------------------------+
// | uram_rd_pkg : shared constants and helpers for the URAM read adapter       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package uram_rd_pkg;

    localparam int STATS_W = 32;

    // Edges from RAM enable to valid mem_dout, which is also the tag pipe length.
    function automatic int rd_latency(input int nbpipe);
        return nbpipe + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uram_rd_fifo.sv
// +----------------------------------------------------------------------------+
// | uram_rd_fifo : synchronous first-word fall-through response buffer         |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module uram_rd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             full;

    assign do_pop   = pop & (cnt != '0);
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(push && full && !do_pop))
                else $error("uram_rd_fifo: push while full");
    end
`endif

endmodule

`default_nettype wire

// File: rtl/uram_rd_adapter.sv
// +----------------------------------------------------------------------------+
// | uram_rd_adapter : credit-based request/response adapter for a pipelined   |
// | URAM port. Optional stats counters via URAM_RD_ADAPTER_STATS_EN.           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module uram_rd_adapter
    import uram_rd_pkg::*;
#(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AWIDTH-1:0]    req_addr,
    input  logic [DWIDTH-1:0]    req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DWIDTH-1:0]    resp_data,
`ifdef URAM_RD_ADAPTER_STATS_EN
    output logic [STATS_W-1:0]   stat_rd_cnt,
    output logic [STATS_W-1:0]   stat_stall_cnt,
`endif
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AWIDTH-1:0]    mem_addr,
    output logic [DWIDTH-1:0]    mem_din,
    input  logic [DWIDTH-1:0]    mem_dout
);

    localparam int LAT = rd_latency(NBPIPE);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [LAT-1:0] tag;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    outstanding;
    logic           accept;
    logic           rd_accept;
    logic           push;
    logic           pop;
    logic           fifo_empty;

    // Credits cover reads in the RAM pipe plus those parked in the buffer,
    // so a push can never find the buffer full.
    assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
    assign req_ready   = rst_n && (outstanding < (CW+1)'(FIFO_DEPTH));

    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_we;
    assign mem_en    = accept;
    assign mem_we    = req_we;
    assign mem_addr  = req_addr;
    assign mem_din   = req_wdata;

    assign push       = tag[LAT-1];
    assign resp_valid = ~fifo_empty;
    assign pop        = resp_valid & resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag <= '0;
        else
            tag <= {tag[LAT-2:0], rd_accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({rd_accept, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    uram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_dout),
        .pop       (pop),
        .pop_data  (resp_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef URAM_RD_ADAPTER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (rd_accept)
                stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (req_valid && !req_ready)
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uram_rd_adapter.sv
// +----------------------------------------------------------------------------+
// | tb_uram_rd_adapter : randomized bench with a queue-based reference model   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uram_rd_adapter;

    localparam int AW   = 12;
    localparam int DW   = 72;
    localparam int LATR = 5;
    localparam int DEP  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
`ifdef URAM_RD_ADAPTER_STATS_EN
    logic [31:0]   stat_rd_cnt, stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    uram_rd_adapter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
`ifdef URAM_RD_ADAPTER_STATS_EN
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout)
    );

    // Behavioural RAM: data appears NBPIPE+1 = 4 edges after enable.
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] p0, p1, p2, p3;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        p0 <= ram[mem_addr];
        end
        p1 <= p0;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_dout = p3;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mm [4096];
    int            cyc, n_rd, n_pop, n_stall;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
    endtask

    // One clock cycle: observe at the falling edge, advance past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            check("req_ready", req_ready, q.size() < DEP);
            check("resp_valid", resp_valid, q.size() > 0 && q[0].cyc + LATR <= cyc);
            check("mem_en", mem_en, req_valid && q.size() < DEP);
            if (mem_en) check("mem_addr", mem_addr, req_addr);
            if (req_valid && !req_ready) n_stall++;
            if (resp_valid && resp_ready && q.size() > 0) begin
                check("resp_data", resp_data, q[0].d);
                void'(q.pop_front());
                n_pop++;
            end
            if (req_valid && req_ready) begin
                if (req_we) mm[req_addr] = req_wdata;
                else begin
                    q.push_back('{d: mm[req_addr], cyc: cyc});
                    n_rd++;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        drive(1'b0, 1'b0, '0, '0);
        resp_ready = 1'b1;
        while (q.size() > 0 && k < 60) begin
            tick();
            k++;
        end
        if (q.size() > 0) check("drain_timeout", 72'(q.size()), 72'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int s, t0, lat;
        logic [DW-1:0] rv;
        for (int i = 0; i < 4096; i++) begin
            rv     = 72'({$urandom, $urandom, $urandom});
            ram[i] = rv;
            mm[i]  = rv;
        end
        cyc = 0; n_rd = 0; n_pop = 0; n_stall = 0;
        rst_n = 1'b1;
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 12'd7, '0);
        @(posedge clk);
        #1;
        do_reset();
        drive(1'b0, 1'b0, '0, '0);
        tick();

        // Write then read back, with first-response latency.
        resp_ready = 1'b1;
        drive(1'b1, 1'b1, 12'd5, 72'hAA);
        tick();
        drive(1'b1, 1'b0, 12'd5, '0);
        t0 = cyc;
        tick();
        drive(1'b0, 1'b0, '0, '0);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (resp_valid) begin
                lat = cyc - t0;
                check("wr_rd_data", resp_data, 72'hAA);
            end
            tick();
        end
        check("first_latency", 72'(lat), 72'(LATR));
        drain();

        // 100 back-to-back reads.
        s = n_stall; t0 = n_pop;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        check("b2b_stalls", 72'(n_stall - s), 72'd0);
        drain();
        check("b2b_responses", 72'(n_pop - t0), 72'd100);

        // Credit limit with the consumer stalled.
        resp_ready = 1'b0;
        t0 = n_rd;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        check("fill_accepts", 72'(n_rd - t0), 72'(DEP));
        check("full_ready", req_ready, 1'b0);
        drive(1'b0, 1'b0, '0, '0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        t0 = n_rd;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        check("one_pop_one_accept", 72'(n_rd - t0), 72'd1);
        drain();

        // Read / write / read keeps order, writes give no response.
        t0 = n_pop;
        drive(1'b1, 1'b0, 12'd1, '0);                     tick();
        drive(1'b1, 1'b1, 12'd2, 72'h1234_5678_9ABC);     tick();
        drive(1'b1, 1'b0, 12'd3, '0);                     tick();
        drain();
        for (int k = 0; k < 8; k++) tick();
        check("rwr_responses", 72'(n_pop - t0), 72'd2);

        // Randomized traffic over a small address window.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom), 1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)),
                  72'({$urandom, $urandom, $urandom}));
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with reads in flight: late RAM data must not be captured.
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        do_reset();
        s = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) s++;
            tick();
        end
        check("no_stale_resp", 72'(s), 72'd0);

`ifdef URAM_RD_ADAPTER_STATS_EN
        do_reset();
        check("stat_rd_reset", 72'(stat_rd_cnt), 72'd0);
        check("stat_stall_reset", 72'(stat_stall_cnt), 72'd0);
        resp_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        drain();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, AW'($urandom), '0);
            tick();
        end
        drain();
        check("stat_rd_cnt", 72'(stat_rd_cnt), 72'd10);
        check("stat_stall_cnt", 72'(stat_stall_cnt), 72'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
